fifo_write_arbiter: RTL and testbench
=====================================

Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the 4-bit FIFO between NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST accepted words.
- Stalls on FIFO full, then rotates priority.
- Sits directly in front of the FIFO write/data_in/full interface; the read side is untouched.

Parameters:
- NUM_REQ, 4, number of producers (2..8).
- DATA_W, 4, word width; matches the FIFO data width.
- MAX_BURST, 2, maximum accepted words per grant before forced rotation (1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  per-producer write request; level, held while the producer has data.
- req_data  input  NUM_REQ*DATA_W  producer words, producer i at bits [i*DATA_W +: DATA_W].
- req_ack  output  NUM_REQ  one-hot pulse: the owner's word is written this cycle. The producer advances its data on the next edge.
- grant  output  NUM_REQ  one-hot registered current owner; all zeros when idle.
- fifo_full  input  1  FIFO full flag.
- fifo_write  output  1  FIFO write strobe.
- fifo_data  output  DATA_W  word to the FIFO data input.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE, grant=0, rr_ptr=0, burst_cnt=0.
  - fifo_write, req_ack and busy go 0 immediately, since they are decoded from state/grant.
  - fifo_data=0.
  - Mid-burst reset drops the grant; the word being presented that cycle is not written.
- FSM states: IDLE, GRANT. State, grant, rr_ptr and burst_cnt are registered.
- IDLE:
  - If req != 0, select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Next cycle: grant=onehot(i), owner=i, burst_cnt=0, state=GRANT.
  - If req=0, stay in IDLE.
  - Arbitration costs exactly one cycle. No write occurs in IDLE.
- GRANT:
  - accept = req[owner] & ~fifo_full (combinational).
  - fifo_write = accept.
  - req_ack = accept ? onehot(owner) : 0.
  - fifo_data = word of owner when in GRANT, else 0.
- GRANT exit and hold rules:
  - accept=1 and burst_cnt==MAX_BURST-1: return to IDLE, rr_ptr=(owner+1) mod NUM_REQ, grant=0.
  - accept=1 otherwise: burst_cnt+1, stay in GRANT.
  - req[owner]=0: release with no write; return to IDLE, rr_ptr=(owner+1) mod NUM_REQ.
  - req[owner]=1 and fifo_full=1: hold. No write, burst_cnt unchanged, grant kept indefinitely; full never causes rotation.
- Requests from non-owners are ignored while in GRANT, and they never receive req_ack.
- Throughput:
  - One word per cycle within a burst.
  - One bubble cycle (IDLE) between grants.
  - Maximum sustained rate MAX_BURST/(MAX_BURST+1).
- fifo_full is trusted as presented.
  - The arbiter never asserts fifo_write while fifo_full=1.
  - It adds no occupancy tracking of its own.
- Wrap-around: rr_ptr and the priority search wrap from NUM_REQ-1 to 0. burst_cnt width is clog2(MAX_BURST+1).
- Invariants:
  - grant is one-hot or zero.
  - req_ack is a subset of grant.
  - fifo_write equals OR(req_ack).
  - busy equals (grant != 0).

Test Plan:
- Reset then single requester: req=0001, req_data[0] gives 3,5,7 on successive acks, fifo_full=0, MAX_BURST=2.
  - Required: grant=0001 at cycle 1.
  - fifo_write high at cycles 1,2 (data 3,5); IDLE at cycle 3; regrant at cycle 4; write 7 at cycle 4.
- All four requesting continuously, fifo_full=0:
  - Grant order 0001,0010,0100,1000,0001.
  - Each owner gets exactly 2 writes, with 1 idle cycle between grants.
- Full stall: owner 0 granted, fifo_full=1 for 5 cycles, then 0.
  - Required: fifo_write=0 and grant=0001 held throughout the 5 cycles.
  - Burst then completes with 2 writes; no rotation during the stall.
- Early release: req=0101, req[0] drops after 1 accepted word.
  - Required: owner 0 writes 1 word, then IDLE.
  - Next grant=0100; rr_ptr=1, so the search skips requester 1, which is not requesting.
- Async reset mid-burst: rst_n low for half a cycle while grant=0010 with accept=1.
  - Required: fifo_write and grant drop without waiting for a clock edge.
  - After release, the first grant goes to the lowest-index requester (rr_ptr=0).
- Wrap priority: rr_ptr=3 with req=1001.
  - Required: grant=1000 first, then 0001.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers.
// Bursts of up to MAX_BURST words per grant; holds on full, rotates after.
//
// Ports:
//   clk, rst_n   rising-edge clock, async active-low reset
//   req          per-producer level request
//   req_data     producer words, producer i at [i*DATA_W +: DATA_W]
//   req_ack      one-hot pulse when the owner's word is written
//   grant        registered one-hot owner, zero when idle
//   fifo_full    FIFO full flag (trusted as presented)
//   fifo_write   FIFO write strobe
//   fifo_data    word presented to the FIFO
//   busy         high while a grant is held
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      fifo_full,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_data,
    output logic                      busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;

    logic [DATA_W-1:0]    words [NUM_REQ];
    logic [PTR_W-1:0]     cand;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_vld;
    logic [PTR_W-1:0]     next_ptr;
    logic                 accept;
    logic                 last_beat;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_words
        assign words[g] = req_data[g*DATA_W +: DATA_W];
    end

    // First requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        cand     = '0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!pick_vld && req[cand]) begin
                pick_vld = 1'b1;
                pick_idx = cand;
            end
        end
    end

    assign next_ptr  = (owner_q == PTR_W'(NUM_REQ - 1)) ?
                       '0 : owner_q + PTR_W'(1);
    assign last_beat = (burst_cnt_q == CNT_W'(MAX_BURST - 1));
    assign accept    = (state_q == GRANT) && req[owner_q] && !fifo_full;

    assign fifo_write = accept;
    assign req_ack    = accept ? grant_q : '0;
    assign grant      = grant_q;
    assign busy       = (state_q == GRANT);
    assign fifo_data  = (state_q == GRANT) ? words[owner_q] : '0;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d     = GRANT;
                    grant_d     = NUM_REQ'(1) << pick_idx;
                    owner_d     = pick_idx;
                    burst_cnt_d = '0;
                end
            end
            GRANT: begin
                // Release on a dropped request or a finished burst;
                // a full FIFO alone just holds the grant.
                if (!req[owner_q] || (accept && last_beat)) begin
                    state_d     = IDLE;
                    grant_d     = '0;
                    rr_ptr_d    = next_ptr;
                    burst_cnt_d = '0;
                end else if (accept) begin
                    burst_cnt_d = burst_cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter: directed scenarios plus a randomized run
// checked against a per-cycle behavioural model of the arbitration rules.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int MB = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_ack;
    logic [N-1:0]   grant;
    logic           fifo_full = 1'b0;
    logic           fifo_write;
    logic [W-1:0]   fifo_data;
    logic           busy;

    int checks = 0;
    int failures = 0;

    fifo_write_arbiter #(
        .NUM_REQ(N),
        .DATA_W(W),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .req_data(req_data),
        .req_ack(req_ack),
        .grant(grant),
        .fifo_full(fifo_full),
        .fifo_write(fifo_write),
        .fifo_data(fifo_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [W-1:0] w);
        req_data[i*W +: W] = w;
    endtask

    // Reset is released 1 time unit after an edge; the following edge
    // samples the requests set by the caller ("cycle 0").
    task automatic do_reset();
        rst_n = 1'b0;
        req = '0;
        fifo_full = 1'b0;
        req_data = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = '1;
        fifo_full = 1'b0;
        req_data = 16'h1234;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (grant !== 4'b0) begin
            failures++;
            $display("FAIL reset_grant got %b want 0000", grant);
        end
        checks++;
        if (fifo_write !== 1'b0) begin
            failures++;
            $display("FAIL reset_write got %b want 0", fifo_write);
        end
        checks++;
        if (req_ack !== 4'b0) begin
            failures++;
            $display("FAIL reset_ack got %b want 0000", req_ack);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (fifo_data !== 4'h0) begin
            failures++;
            $display("FAIL reset_data got %h want 0", fifo_data);
        end
    endtask

    task automatic test_single();
        logic [3:0] eg [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0001};
        logic       ew [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [3:0] wd [4] = '{4'd3, 4'd5, 4'd7, 4'd7};
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            set_word(0, wd[c-1]);
            @(negedge clk);
            checks++;
            if (grant !== eg[c-1]) begin
                failures++;
                $display("FAIL single_grant c%0d got %b want %b",
                         c, grant, eg[c-1]);
            end
            checks++;
            if (fifo_write !== ew[c-1]) begin
                failures++;
                $display("FAIL single_write c%0d got %b want %b",
                         c, fifo_write, ew[c-1]);
            end
            if (ew[c-1]) begin
                checks++;
                if (fifo_data !== wd[c-1]) begin
                    failures++;
                    $display("FAIL single_data c%0d got %0d want %0d",
                             c, fifo_data, wd[c-1]);
                end
            end
        end
        req = '0;
    endtask

    task automatic test_rotation();
        int wr [N];
        logic [3:0] eg;
        int own;
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < N; i++) begin
            set_word(i, W'(i + 8));
            wr[i] = 0;
        end
        for (int c = 1; c <= 13; c++) begin
            next_cycle();
            @(negedge clk);
            own = ((c - 1) / 3) % N;
            eg = ((c - 1) % 3 == 2) ? 4'b0 : 4'(1 << own);
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL rot_grant c%0d got %b want %b", c, grant, eg);
            end
            checks++;
            if (fifo_write !== (eg != 0)) begin
                failures++;
                $display("FAIL rot_write c%0d got %b want %b",
                         c, fifo_write, eg != 0);
            end
            if (eg != 0) begin
                checks++;
                if (fifo_data !== W'(own + 8)) begin
                    failures++;
                    $display("FAIL rot_data c%0d got %h want %h",
                             c, fifo_data, own + 8);
                end
            end
            for (int i = 0; i < N; i++)
                if (c <= 12 && fifo_write && req_ack[i]) wr[i]++;
        end
        for (int i = 0; i < N; i++) begin
            checks++;
            if (wr[i] != MB) begin
                failures++;
                $display("FAIL rot_count p%0d got %0d want %0d", i, wr[i], MB);
            end
        end
        req = '0;
    endtask

    task automatic test_full_stall();
        logic [3:0] eg [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001,
                               4'b0001, 4'b0001, 4'b0001, 4'b0000};
        logic       ew [8] = '{1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        req = 4'b0101;
        fifo_full = 1'b1;
        set_word(0, 4'hA);
        for (int c = 1; c <= 8; c++) begin
            next_cycle();
            if (c == 6) fifo_full = 1'b0;
            @(negedge clk);
            checks++;
            if (grant !== eg[c-1]) begin
                failures++;
                $display("FAIL stall_grant c%0d got %b want %b",
                         c, grant, eg[c-1]);
            end
            checks++;
            if (fifo_write !== ew[c-1]) begin
                failures++;
                $display("FAIL stall_write c%0d got %b want %b",
                         c, fifo_write, ew[c-1]);
            end
        end
        req = '0;
    endtask

    task automatic test_early_release();
        logic [3:0] rq [4] = '{4'b0101, 4'b0100, 4'b0100, 4'b0100};
        logic [3:0] eg [4] = '{4'b0001, 4'b0001, 4'b0000, 4'b0100};
        logic       ew [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        req = 4'b0101;
        for (int c = 1; c <= 4; c++) begin
            next_cycle();
            req = rq[c-1];
            @(negedge clk);
            checks++;
            if (grant !== eg[c-1]) begin
                failures++;
                $display("FAIL early_grant c%0d got %b want %b",
                         c, grant, eg[c-1]);
            end
            checks++;
            if (fifo_write !== ew[c-1]) begin
                failures++;
                $display("FAIL early_write c%0d got %b want %b",
                         c, fifo_write, ew[c-1]);
            end
        end
        req = '0;
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0011;
        repeat (4) next_cycle();
        #2;
        checks++;
        if (grant !== 4'b0010 || fifo_write !== 1'b1) begin
            failures++;
            $display("FAIL areset_pre got g=%b w=%b want g=0010 w=1",
                     grant, fifo_write);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (grant !== 4'b0 || fifo_write !== 1'b0) begin
            failures++;
            $display("FAIL areset_drop got g=%b w=%b want g=0000 w=0",
                     grant, fifo_write);
        end
        checks++;
        if (busy !== 1'b0 || req_ack !== 4'b0) begin
            failures++;
            $display("FAIL areset_busy got b=%b a=%b want b=0 a=0000",
                     busy, req_ack);
        end
        #4;
        rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++;
        if (grant !== 4'b0001) begin
            failures++;
            $display("FAIL areset_regrant got %b want 0001", grant);
        end
        req = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] rq [7] = '{4'b0100, 4'b0100, 4'b1001, 4'b1001,
                               4'b1001, 4'b1001, 4'b1001};
        logic [3:0] eg [7] = '{4'b0100, 4'b0100, 4'b0000, 4'b1000,
                               4'b1000, 4'b0000, 4'b0001};
        logic       ew [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 7; c++) begin
            next_cycle();
            req = rq[c-1];
            @(negedge clk);
            checks++;
            if (grant !== eg[c-1]) begin
                failures++;
                $display("FAIL wrap_grant c%0d got %b want %b",
                         c, grant, eg[c-1]);
            end
            checks++;
            if (fifo_write !== ew[c-1]) begin
                failures++;
                $display("FAIL wrap_write c%0d got %b want %b",
                         c, fifo_write, ew[c-1]);
            end
        end
        req = '0;
    endtask

    // Model: owner (-1 when idle), rotation pointer and words taken so far.
    task automatic test_random();
        int m_owner = -1;
        int m_rr = 0;
        int m_cnt = 0;
        int acked = -1;
        int idx;
        logic [3:0] eg, eack;
        logic       ew;
        logic [W-1:0] ed;
        do_reset();
        for (int i = 0; i < N; i++) set_word(i, W'($urandom));
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++)
                req[i] = ($urandom_range(0, 9) < 7);
            fifo_full = ($urandom_range(0, 3) == 0);
            if (acked >= 0) set_word(acked, W'($urandom));
            @(negedge clk);
            eg = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0;
            ew = (m_owner >= 0) && req[m_owner] && !fifo_full;
            eack = ew ? eg : 4'b0;
            ed = (m_owner >= 0) ? req_data[m_owner*W +: W] : '0;
            checks++;
            if (grant !== eg) begin
                failures++;
                $display("FAIL rnd_grant c%0d got %b want %b", c, grant, eg);
            end
            checks++;
            if (fifo_write !== ew) begin
                failures++;
                $display("FAIL rnd_write c%0d got %b want %b",
                         c, fifo_write, ew);
            end
            checks++;
            if (req_ack !== eack) begin
                failures++;
                $display("FAIL rnd_ack c%0d got %b want %b", c, req_ack, eack);
            end
            checks++;
            if (fifo_data !== ed) begin
                failures++;
                $display("FAIL rnd_data c%0d got %h want %h",
                         c, fifo_data, ed);
            end
            checks++;
            if (busy !== (m_owner >= 0)) begin
                failures++;
                $display("FAIL rnd_busy c%0d got %b want %b",
                         c, busy, m_owner >= 0);
            end
            acked = ew ? m_owner : -1;
            if (m_owner < 0) begin
                for (int k = N - 1; k >= 0; k--) begin
                    idx = (m_rr + k) % N;
                    if (req[idx]) m_owner = idx;
                end
                m_cnt = 0;
            end else if (!req[m_owner]) begin
                m_rr = (m_owner + 1) % N;
                m_owner = -1;
            end else if (!fifo_full) begin
                m_cnt++;
                if (m_cnt == MB) begin
                    m_rr = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end
            next_cycle();
        end
        req = '0;
        fifo_full = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_full_stall();
        test_early_release();
        test_async_reset();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
